mma_icb_mux: RTL and testbench

// - Shares the single ICB master port of the MMA subsystem among five loaders: IA, weight, bias, quant, OA.
// - Sits directly downstream of the MMA controller. The controller's icb_sel picks which loader may issue commands.
// - A tag FIFO records the owner of every outstanding command. Responses therefore return to the right loader even if icb_sel changes mid-flight.

---
 rtl/mma_icb_mux.sv | 156 +++++++++++++++
 tb/tb_mma_icb_mux.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mma_icb_mux.sv
// mma_icb_mux: shares the MMA ICB master port among the IA/weight/bias/quant/OA loaders and
// steers responses back in order via an owner-tag FIFO. Define ICB_MUX_ERR_CNT_EN to add err_cnt.
module mma_icb_mux #(
    parameter int NUM_MASTERS = 5,
    parameter int ADDR_WIDTH  = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int OUTS_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
`ifdef ICB_MUX_ERR_CNT_EN
    output logic [15:0]                           err_cnt,
`endif
    input  logic [2:0]                            icb_sel,
    input  logic [NUM_MASTERS-1:0]                m_cmd_valid,
    output logic [NUM_MASTERS-1:0]                m_cmd_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_cmd_addr,
    input  logic [NUM_MASTERS-1:0]                m_cmd_read,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]      m_cmd_wdata,
    input  logic [NUM_MASTERS*BUS_WIDTH/8-1:0]    m_cmd_wmask,
    output logic [NUM_MASTERS-1:0]                m_rsp_valid,
    input  logic [NUM_MASTERS-1:0]                m_rsp_ready,
    output logic [BUS_WIDTH-1:0]                  m_rsp_rdata,
    output logic                                  m_rsp_err,
    output logic                                  s_cmd_valid,
    input  logic                                  s_cmd_ready,
    output logic [ADDR_WIDTH-1:0]                 s_cmd_addr,
    output logic                                  s_cmd_read,
    output logic [BUS_WIDTH-1:0]                  s_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0]                s_cmd_wmask,
    input  logic                                  s_rsp_valid,
    output logic                                  s_rsp_ready,
    input  logic [BUS_WIDTH-1:0]                  s_rsp_rdata,
    input  logic                                  s_rsp_err,
    output logic [$clog2(OUTS_DEPTH):0]           outstanding,
    output logic                                  busy
);

    localparam int MASK_W = BUS_WIDTH / 8;
    localparam int PTR_W  = $clog2(OUTS_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [2:0]       tag_mem_q [OUTS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    // Holds the command path closed for the cycle following a reset edge.
    logic             init_q;

    logic             tag_full_s;
    logic             tag_empty_s;
    logic             sel_ok_s;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       head_tag_s;

    assign tag_full_s  = (cnt_q == CNT_W'(OUTS_DEPTH));
    assign tag_empty_s = (cnt_q == {CNT_W{1'b0}});
    assign head_tag_s  = tag_mem_q[rd_ptr_q];

    // Command mux: the selected loader's slice goes straight to the shared bus.
    always_comb begin
        sel_ok_s    = (int'(icb_sel) < NUM_MASTERS) && !tag_full_s && !init_q;
        s_cmd_valid = 1'b0;
        s_cmd_addr  = {ADDR_WIDTH{1'b0}};
        s_cmd_read  = 1'b0;
        s_cmd_wdata = {BUS_WIDTH{1'b0}};
        s_cmd_wmask = {MASK_W{1'b0}};
        m_cmd_ready = {NUM_MASTERS{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_ok_s && (icb_sel == 3'(i))) begin
                s_cmd_valid    = m_cmd_valid[i];
                s_cmd_addr     = m_cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_cmd_read     = m_cmd_read[i];
                s_cmd_wdata    = m_cmd_wdata[i*BUS_WIDTH +: BUS_WIDTH];
                s_cmd_wmask    = m_cmd_wmask[i*MASK_W +: MASK_W];
                m_cmd_ready[i] = s_cmd_ready;
            end else begin
                m_cmd_ready[i] = 1'b0;
            end
        end
    end

    // Response demux: the oldest tag owns the response channel.
    always_comb begin
        m_rsp_valid = {NUM_MASTERS{1'b0}};
        s_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!tag_empty_s && (head_tag_s == 3'(i))) begin
                m_rsp_valid[i] = s_rsp_valid;
                s_rsp_ready    = m_rsp_ready[i];
            end else begin
                m_rsp_valid[i] = 1'b0;
            end
        end
        m_rsp_rdata = s_rsp_rdata;
        m_rsp_err   = s_rsp_err;
    end

    // Tag FIFO next-state: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        push_s   = s_cmd_valid & s_cmd_ready;
        pop_s    = s_rsp_valid & s_rsp_ready;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer, count and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= (cnt_d != {CNT_W{1'b0}});
            init_q   <= 1'b0;
        end
    end

    // Tag storage; entries are only read while valid so they need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_q[wr_ptr_q] <= icb_sel;
        end
    end

    assign outstanding = cnt_q;
    assign busy        = busy_q;

`ifdef ICB_MUX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of error responses delivered to a loader.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else if (pop_s && s_rsp_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mma_icb_mux.sv
// tb_mma_icb_mux: directed scenarios plus randomized traffic for mma_icb_mux, checked by a
// negedge monitor against an owner-queue reference model.
module tb_mma_icb_mux;

    localparam int NM    = 5;
    localparam int AW    = 32;
    localparam int BW    = 32;
    localparam int MW    = BW / 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       icb_sel;
    logic [NM-1:0]    m_cmd_valid, m_cmd_ready, m_cmd_read;
    logic [NM*AW-1:0] m_cmd_addr;
    logic [NM*BW-1:0] m_cmd_wdata;
    logic [NM*MW-1:0] m_cmd_wmask;
    logic [NM-1:0]    m_rsp_valid, m_rsp_ready;
    logic [BW-1:0]    m_rsp_rdata;
    logic             m_rsp_err;
    logic             s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [AW-1:0]    s_cmd_addr;
    logic [BW-1:0]    s_cmd_wdata;
    logic [MW-1:0]    s_cmd_wmask;
    logic             s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [BW-1:0]    s_rsp_rdata;
    logic [2:0]       outstanding;
    logic             busy;
`ifdef ICB_MUX_ERR_CNT_EN
    logic [15:0]      err_cnt;
`endif

    mma_icb_mux #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
`ifdef ICB_MUX_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .icb_sel(icb_sel),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_addr(s_cmd_addr),
        .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err),
        .outstanding(outstanding), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: owners of accepted commands, oldest first.
    int          exp_q[$];
    logic [15:0] err_model = 16'h0000;
    logic        rst_seen  = 1'b1;
    logic        mon_en    = 1'b0;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin : monitor
        int            sel;
        int            h;
        logic          exp_sv, exp_sr, cmd_hs;
        logic [NM-1:0] exp_rdy, exp_rv;
        if (mon_en) begin
            if (rst_seen) begin
                exp_q.delete();
                err_model = 16'h0000;
            end
            chk("outstanding", outstanding, exp_q.size());
            chk("busy", busy, exp_q.size() != 0);
`ifdef ICB_MUX_ERR_CNT_EN
            chk("err_cnt", err_cnt, err_model);
`endif
            sel     = int'(icb_sel);
            exp_sv  = 1'b0;
            exp_rdy = '0;
            if (sel < NM && exp_q.size() < DEPTH && !rst_seen) begin
                exp_sv       = m_cmd_valid[sel];
                exp_rdy[sel] = s_cmd_ready;
            end
            chk("s_cmd_valid", s_cmd_valid, exp_sv);
            chk("m_cmd_ready", m_cmd_ready, exp_rdy);
            if (exp_sv) begin
                chk("s_cmd_addr", s_cmd_addr, m_cmd_addr[sel*AW +: AW]);
                chk("s_cmd_read", s_cmd_read, m_cmd_read[sel]);
                chk("s_cmd_wdata", s_cmd_wdata, m_cmd_wdata[sel*BW +: BW]);
                chk("s_cmd_wmask", s_cmd_wmask, m_cmd_wmask[sel*MW +: MW]);
            end
            cmd_hs = exp_sv && s_cmd_ready;
            exp_rv = '0;
            exp_sr = 1'b0;
            if (exp_q.size() > 0) begin
                h         = exp_q[0];
                exp_rv[h] = s_rsp_valid;
                exp_sr    = m_rsp_ready[h];
            end
            chk("m_rsp_valid", m_rsp_valid, exp_rv);
            chk("s_rsp_ready", s_rsp_ready, exp_sr);
            if (exp_rv != '0) begin
                chk("m_rsp_rdata", m_rsp_rdata, s_rsp_rdata);
                chk("m_rsp_err", m_rsp_err, s_rsp_err);
            end
            if (s_rsp_valid && exp_sr) begin
                void'(exp_q.pop_front());
                if (s_rsp_err && err_model != 16'hFFFF) err_model = err_model + 16'h0001;
            end
            if (cmd_hs) exp_q.push_back(sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_cmd_valid = '0;
        m_rsp_ready = '0;
        s_cmd_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_err   = 1'b0;
    endtask

    task automatic drain();
        idle();
        s_rsp_valid = 1'b1;
        m_rsp_ready = '1;
        repeat (DEPTH + 2) tick();
        idle();
        #2 chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        rst = 1'b1;
        icb_sel = 3'd0;
        m_cmd_addr = '0;
        m_cmd_read = '0;
        m_cmd_wdata = '0;
        m_cmd_wmask = '0;
        s_rsp_rdata = '0;
        idle();
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        #2 chk("post_reset_ready", m_cmd_ready, 0);
        chk("post_reset_outstanding", outstanding, 0);
        tick();

        // Routing: weight reads 0x100.
        icb_sel = 3'd1;
        m_cmd_valid = 5'b00010;
        m_cmd_read = 5'b00010;
        m_cmd_addr[1*AW +: AW] = 32'h0000_0100;
        s_cmd_ready = 1'b1;
        #2 chk("route_addr", s_cmd_addr, 32'h0000_0100);
        chk("route_ready", m_cmd_ready, 5'b00010);
        tick();
        idle();
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'hA5A5_0001;
        m_rsp_ready = '1;
        #2 chk("route_rsp_valid", m_rsp_valid, 5'b00010);
        chk("route_rdata", m_rsp_rdata, 32'hA5A5_0001);
        tick();
        idle();

        // Selection change while IA reads are in flight.
        icb_sel = 3'd0;
        m_cmd_valid = 5'b00001;
        m_cmd_read = 5'b00001;
        s_cmd_ready = 1'b1;
        repeat (2) tick();
        icb_sel = 3'd4;
        m_cmd_valid = 5'b10000;
        m_cmd_read = 5'b00000;
        tick();
        idle();
        #2 chk("selchg_out3", outstanding, 3);
        s_rsp_valid = 1'b1;
        m_rsp_ready = '1;
        #1 chk("selchg_rsp1", m_rsp_valid, 5'b00001);
        tick();
        #2 chk("selchg_out2", outstanding, 2);
        chk("selchg_rsp2", m_rsp_valid, 5'b00001);
        tick();
        #2 chk("selchg_out1", outstanding, 1);
        chk("selchg_rsp3", m_rsp_valid, 5'b10000);
        tick();
        #2 chk("selchg_out0", outstanding, 0);
        idle();

        // Full tag FIFO blocks a fifth command until a response retires.
        icb_sel = 3'd2;
        m_cmd_valid = 5'b00100;
        s_cmd_ready = 1'b1;
        repeat (4) tick();
        #2 chk("full_out4", outstanding, 4);
        chk("full_blocked", m_cmd_ready, 5'b00000);
        tick();
        s_rsp_valid = 1'b1;
        m_rsp_ready = '1;
        #2 chk("full_blocked_on_pop", m_cmd_ready, 5'b00000);
        tick();
        s_rsp_valid = 1'b0;
        #2 chk("full_accept_after_pop", m_cmd_ready, 5'b00100);
        tick();
        drain();

        // Invalid selections never reach the bus.
        m_cmd_valid = '1;
        s_cmd_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            icb_sel = (k < 10) ? 3'd5 : ((k < 20) ? 3'd7 : 3'd6);
            #2 chk("badsel_valid", s_cmd_valid, 0);
            chk("badsel_ready", m_cmd_ready, 0);
            tick();
        end
        idle();

        // Stray response with nothing outstanding stalls.
        s_rsp_valid = 1'b1;
        m_rsp_ready = '1;
        #2 chk("empty_s_rsp_ready", s_rsp_ready, 0);
        chk("empty_m_rsp_valid", m_rsp_valid, 0);
        tick();
        idle();

        // Reset with three commands outstanding.
        icb_sel = 3'd3;
        m_cmd_valid = 5'b01000;
        s_cmd_ready = 1'b1;
        repeat (3) tick();
        idle();
        #2 chk("prerst_out3", outstanding, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cmd_valid = 5'b01000;
        s_cmd_ready = 1'b1;
        #2 chk("rst_outstanding", outstanding, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", m_cmd_ready, 0);
        tick();
        #2 chk("rst_then_accept", m_cmd_ready, 5'b01000);
        tick();
        drain();

        // Three error responses then a clean one.
        icb_sel = 3'd2;
        m_cmd_valid = 5'b00100;
        s_cmd_ready = 1'b1;
        repeat (4) tick();
        idle();
        s_rsp_valid = 1'b1;
        m_rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            s_rsp_err = (k < 3);
            tick();
        end
        idle();
`ifdef ICB_MUX_ERR_CNT_EN
        #2 chk("err_cnt_3", err_cnt, 3);
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            icb_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            m_cmd_valid = NM'($urandom);
            m_cmd_read = NM'($urandom);
            for (int m = 0; m < NM; m++) begin
                m_cmd_addr[m*AW +: AW] = $urandom;
                m_cmd_wdata[m*BW +: BW] = $urandom;
                m_cmd_wmask[m*MW +: MW] = MW'($urandom);
            end
            s_cmd_ready = ($urandom_range(0, 3) != 0);
            s_rsp_valid = ($urandom_range(0, 1) != 0);
            s_rsp_rdata = $urandom;
            s_rsp_err = ($urandom_range(0, 3) == 0);
            m_rsp_ready = NM'($urandom);
            tick();
        end
        rst = 1'b0;
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
